// File: rtl/fifo_arb_pkg.sv
// Shared defaults and state encoding for the fifo write arbiter.
package fifo_arb_pkg;

   localparam int NREQ_DEF      = 4;
   localparam int DW_DEF        = 8;
   localparam int DEPTH_DEF     = 64;
   localparam int BURST_LEN_DEF = 4;

   // Arbiter states: ARB searches all requesters, HOLD locks onto one burst owner.
   localparam logic [0:0] ARB  = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority search. Returns the first set
// request at or above ptr, wrapping from NREQ-1 back to 0, as a one-hot
// vector plus its index. Both outputs are zero when no request is set.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] onehot,
   output logic [PW-1:0]   idx
);

   logic [PW-1:0] cand;
   logic          found;

   // Walk the requesters starting at ptr and latch the first one found.
   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      cand   = '0;
      for (int off = 0; off < NREQ; off++) begin
         cand = PW'((int'(ptr) + off) % NREQ);
         if (!found && req[cand]) begin
            found       = 1'b1;
            onehot[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter feeding one downstream fifo write port.
// The grant is combinational; the fifo write strobe, data and winner index
// are registered one cycle later. Define FIFO_ARB_BURST_EN to let a winner
// keep the port for up to BURST_LEN consecutive beats.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ      = NREQ_DEF,
   parameter int DW        = DW_DEF,
   parameter int DEPTH     = DEPTH_DEF,
   parameter int BURST_LEN = BURST_LEN_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic [7:0]         fifo_count,
   output logic [NREQ-1:0]    gnt,
   output logic               fifo_wr_en,
   output logic [DW-1:0]      fifo_data,
   output logic [1:0]         grant_id
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   eff_ptr;
   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] pick_onehot;
   logic [PW-1:0]   pick_idx;
   logic            space;
   logic            grant;
   logic [DW-1:0]   sel_data;

   logic            fifo_wr_en_q, fifo_wr_en_d;
   logic [DW-1:0]   fifo_data_q, fifo_data_d;
   logic [1:0]      grant_id_q, grant_id_d;

   function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
      return PW'((int'(i) + 1) % NREQ);
   endfunction

   // Room exists only if the write already in flight still leaves a free slot.
   assign space = ({1'b0, fifo_count} + {8'd0, fifo_wr_en_q}) < 9'(DEPTH);

`ifdef FIFO_ARB_BURST_EN
   localparam int BW = $clog2(BURST_LEN + 1);

   logic [0:0]      state_q, state_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic [PW-1:0]   hold_id_q, hold_id_d;
   logic [NREQ-1:0] hold_mask;
   logic            in_hold;

   // While the burst owner still requests, only it is eligible; once it drops
   // we arbitrate in the same cycle starting just past the owner.
   always_comb begin
      hold_mask = '0;
      for (int i = 0; i < NREQ; i++) begin
         hold_mask[i] = (hold_id_q == PW'(i));
      end
      in_hold = (state_q == HOLD) && (|(req & hold_mask));
      if (in_hold) begin
         eligible = req & hold_mask;
         eff_ptr  = hold_id_q;
      end else if (state_q == HOLD) begin
         eligible = req;
         eff_ptr  = next_idx(hold_id_q);
      end else begin
         eligible = req;
         eff_ptr  = ptr_q;
      end
   end

   // Burst bookkeeping: count beats, release the lock at BURST_LEN, and stall
   // untouched when the fifo has no room.
   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      hold_id_d = hold_id_q;
      ptr_d     = eff_ptr;
      if (in_hold) begin
         ptr_d = ptr_q;
         if (grant) begin
            beat_d = beat_q + 1'b1;
            if (int'(beat_q) + 1 >= BURST_LEN) begin
               state_d = ARB;
               ptr_d   = next_idx(hold_id_q);
            end
         end
      end else begin
         state_d = ARB;
         if (grant) begin
            if (BURST_LEN <= 1) begin
               ptr_d = next_idx(pick_idx);
            end else begin
               state_d   = HOLD;
               hold_id_d = pick_idx;
               beat_d    = BW'(1);
            end
         end
      end
   end

   // Burst state registers; reset abandons any burst in progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ARB;
         beat_q    <= '0;
         hold_id_q <= '0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         hold_id_q <= hold_id_d;
      end
   end
`else
   // Plain round robin: everyone is eligible and the pointer moves past each winner.
   always_comb begin
      eligible = req;
      eff_ptr  = ptr_q;
      ptr_d    = grant ? next_idx(pick_idx) : ptr_q;
   end
`endif

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req    (eligible),
      .ptr    (eff_ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

   // The grant is suppressed while in reset or when the fifo cannot take a beat.
   always_comb begin
      gnt   = (rst && space) ? pick_onehot : '0;
      grant = |gnt;
   end

   // Select the winner's data slice without a variable-width part select.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_idx == PW'(i)) begin
            sel_data = req_data[i*DW +: DW];
         end
      end
   end

   // Next values for the registered fifo write port; data and id hold when idle.
   always_comb begin
      fifo_wr_en_d = grant;
      fifo_data_d  = grant ? sel_data : fifo_data_q;
      grant_id_d   = grant ? 2'(pick_idx) : grant_id_q;
   end

   // Output and pointer registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q        <= '0;
         fifo_wr_en_q <= 1'b0;
         fifo_data_q  <= '0;
         grant_id_q   <= '0;
      end else begin
         ptr_q        <= ptr_d;
         fifo_wr_en_q <= fifo_wr_en_d;
         fifo_data_q  <= fifo_data_d;
         grant_id_q   <= grant_id_d;
      end
   end

   assign fifo_wr_en = fifo_wr_en_q;
   assign fifo_data  = fifo_data_q;
   assign grant_id   = grant_id_q;

endmodule
